// File: rtl/exp_seq_ctrl_pkg.sv
// Package for the exponentiation sequencer.
//   EXP_WIDTH : default operand/result width
//   state_t   : controller state, 2-bit encoding
package exp_seq_ctrl_pkg;

    localparam int EXP_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        MULT   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/exp_seq_ctrl_if.sv
// Handshake/data bundle for the exponentiation sequencer.
//   start  : request from master, sampled only while the sequencer is IDLE
//   base   : operand, captured on the accepted start
//   exp    : exponent, captured on the accepted start
//   busy   : high while squaring or multiplying
//   done   : one-cycle pulse, result valid in that cycle
//   result : final value, held until the next completion
//   state  : controller state for observation
// Handshake: start is a request accepted only in a cycle where state is IDLE;
// once accepted, start/base/exp are ignored until done has pulsed and the
// sequencer has returned to IDLE.
interface exp_seq_ctrl_if
    import exp_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = EXP_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    state_t           state;

    modport master (
        output start, base, exp,
        input  busy, done, result, state
    );

    modport slave (
        input  start, base, exp,
        output busy, done, result, state
    );
endinterface

// File: rtl/exp_seq_ctrl_mul.sv
// exp_mul: combinational truncating multiplier.
//   a, b : WIDTH-bit unsigned operands
//   p    : low WIDTH bits of a*b
module exp_mul #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);
    logic [2*WIDTH-1:0] full;

    assign full = a * b;
    assign p    = full[WIDTH-1:0];
endmodule

// File: rtl/exp_seq_ctrl.sv
// exp_seq_ctrl: multi-cycle base**exp mod 2**WIDTH using left-to-right
// square-and-multiply with a single shared truncating multiplier.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, abandons any operation in flight
//   bus : exp_seq_ctrl_if slave (start/base/exp in, busy/done/result/state out)
module exp_seq_ctrl
    import exp_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = EXP_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    exp_seq_ctrl_if.slave bus
);
    localparam int IDXW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [IDXW-1:0]  idx, idx_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] base_q, base_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic [WIDTH-1:0] mul_b, prod;
    logic             busy, done;

    // Second operand is base only in MULT; SQUARE (and don't-care states) use acc.
    assign mul_b = (state == MULT) ? base_q : acc;

    exp_mul #(.WIDTH(WIDTH)) u_mul (
        .a (acc),
        .b (mul_b),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            result_q <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            acc      <= acc_n;
            base_q   <= base_n;
            exp_q    <= exp_n;
            result_q <= result_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        acc_n    = acc;
        base_n   = base_q;
        exp_n    = exp_q;
        result_n = result_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    base_n  = bus.base;
                    exp_n   = bus.exp;
                    acc_n   = WIDTH'(1);
                    idx_n   = IDXW'(WIDTH - 1);
                    state_n = SQUARE;
                end
            end
            SQUARE: begin
                busy  = 1'b1;
                acc_n = prod;
                // A set exponent bit defers the idx check to the following MULT.
                if (exp_q[idx]) begin
                    state_n = MULT;
                end else if (idx == '0) begin
                    state_n  = DONE;
                    result_n = prod;
                end else begin
                    idx_n = idx - IDXW'(1);
                end
            end
            MULT: begin
                busy  = 1'b1;
                acc_n = prod;
                if (idx == '0) begin
                    state_n  = DONE;
                    result_n = prod;
                end else begin
                    idx_n   = idx - IDXW'(1);
                    state_n = SQUARE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
    assign bus.state  = state;
endmodule

// File: tb/tb_exp_seq_ctrl.sv
// Directed bench for exp_seq_ctrl (WIDTH=8).
module tb_exp_seq_ctrl;
    import exp_seq_ctrl_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   busy_total;
    int   done_total;
    logic [W-1:0] exp_q[$];

    exp_seq_ctrl_if #(.WIDTH(W)) bus ();

    exp_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running counts sampled on the falling edge.
    initial begin
        busy_total = 0;
        done_total = 0;
        forever begin
            @(negedge clk);
            if (bus.busy) busy_total = busy_total + 1;
            if (bus.done) done_total = done_total + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Wait for done; returns cycles elapsed (0 on timeout).
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(lat != 0), 32'd1);
    endtask

    // One complete operation; start is dropped and operands scrambled right
    // after acceptance to show they are not re-sampled.
    task automatic do_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                         input logic [W-1:0] want, input int n);
        int b0, d0, lat;
        logic [W-1:0] exp_val;
        exp_q.push_back(want);
        bus.start = 1'b1;
        bus.base  = b;
        bus.exp   = e;
        b0 = busy_total;
        d0 = done_total;
        tick();
        bus.start = 1'b0;
        bus.base  = W'($urandom_range(0, 255));
        bus.exp   = W'($urandom_range(0, 255));
        lat = 0;
        for (int i = 2; i <= 100; i++) begin
            if (bus.done) begin
                lat = i - 1;
                break;
            end
            tick();
        end
        check({tag, "_timeout"}, 32'(lat != 0), 32'd1);
        exp_val = exp_q.pop_front();
        check({tag, "_result"}, 32'(bus.result), 32'(exp_val));
        check({tag, "_latency"}, 32'(lat), 32'(n + 1));
        tick();
        check({tag, "_busy_cycles"}, 32'(busy_total - b0), 32'(n));
        check({tag, "_done_count"}, 32'(done_total - d0), 32'd1);
        check({tag, "_result_hold"}, 32'(bus.result), 32'(want));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b0, d0, lat, gap;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.base  = '0;
        bus.exp   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", 32'(bus.state), 32'(IDLE));
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);

        do_op("pow3_5", 8'd3, 8'd5, 8'd243, 10);
        do_op("pow2_8", 8'd2, 8'd8, 8'd0, 9);
        do_op("pow0_0", 8'd0, 8'd0, 8'd1, 8);
        do_op("pow7_255", 8'd7, 8'd255, 8'd183, 16);
        do_op("pow0_5", 8'd0, 8'd5, 8'd0, 10);
        do_op("pow5_0", 8'd5, 8'd0, 8'd1, 8);

        // start pulsed mid-operation must be ignored
        b0 = busy_total;
        d0 = done_total;
        bus.start = 1'b1;
        bus.base  = 8'd3;
        bus.exp   = 8'd5;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.base  = 8'd5;
        bus.exp   = 8'd1;
        tick();
        bus.start = 1'b0;
        wait_done("midstart", lat);
        check("midstart_result", 32'(bus.result), 32'd243);
        tick();
        check("midstart_state", 32'(bus.state), 32'(IDLE));
        repeat (15) tick();
        check("midstart_done_count", 32'(done_total - d0), 32'd1);
        check("midstart_busy_cycles", 32'(busy_total - b0), 32'd10);

        // reset in the fourth cycle of an operation
        d0 = done_total;
        bus.start = 1'b1;
        bus.base  = 8'd3;
        bus.exp   = 8'd5;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 32'(bus.state), 32'(IDLE));
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_result", 32'(bus.result), 32'd0);
        repeat (15) tick();
        check("midrst_no_done", 32'(done_total - d0), 32'd0);
        do_op("pow3_2", 8'd3, 8'd2, 8'd9, 9);

        // start held high: back-to-back operations
        bus.start = 1'b1;
        bus.base  = 8'd3;
        bus.exp   = 8'd5;
        wait_done("held1", lat);
        check("held1_latency", 32'(lat), 32'd11);
        check("held1_result", 32'(bus.result), 32'd243);
        bus.base = 8'd2;
        bus.exp  = 8'd3;
        gap = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.done) begin
                gap = i;
                break;
            end
            if (bus.result !== 8'd243) begin
                check("held_result_hold", 32'(bus.result), 32'd243);
                break;
            end
        end
        bus.start = 1'b0;
        check("held_gap", 32'(gap), 32'd12);
        check("held2_result", 32'(bus.result), 32'd8);
        tick();
        tick();
        check("held_stop_state", 32'(bus.state), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
